// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle integer execute unit for the RV32 EX stage.
// Logic/arithmetic ops complete in one cycle; shifts advance one bit per
// cycle. Results are returned on a valid/ready handshake.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - synchronous pipeline flush, aborts in-flight op
//   in_valid/in_ready   - request handshake
//   alu_control      - 4-bit operation code
//   a, b             - operands (shift amount = b[$clog2(XLEN)-1:0])
//   out_valid/out_ready - result handshake
//   result, zero, err   - registered result, result==0, undefined-op flag
//   busy             - high while a multi-cycle shift is in progress
module iterative_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001
  } op_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;
  logic [XLEN-1:0] sh_next;

  assign shamt     = b[SHW-1:0];
  assign is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                     (alu_control == OP_SRA);
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

  // Single-cycle datapath. Shift codes return `a`, which is the correct
  // answer only for a zero shift amount; non-zero shifts go through SHIFT.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
      OP_SLTU: alu_res[0] = a < b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit shift step. SRA replicates the current MSB, which never changes
  // during an arithmetic shift and so always equals the original a[XLEN-1].
  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {sh_q[XLEN-2:0], 1'b0};
      OP_SRA:  sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: sh_next = {1'b0, sh_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    op_d     = op_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          sh_d  = sh_next;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d = sh_next;
            zero_d   = (sh_next == '0);
            err_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase

      // Accept is only possible in IDLE or a draining DONE, so it overrides
      // whatever the state-specific branch above decided.
      if (accept) begin
        if (is_shift && (shamt != '0)) begin
          sh_d    = a;
          cnt_d   = shamt;
          op_d    = alu_control;
          state_d = S_SHIFT;
        end else begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          err_d    = alu_err;
          state_d  = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      op_q     <= OP_AND;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle integer execute unit for the RV32 pipeline's EX stage. It consumes the 4-bit `alu_control` operation codes generated by the ALU control decoder and produces results on a valid/ready handshake. Logic and arithmetic ops complete in one cycle. Shifts run one bit per cycle to keep the barrel shifter off the EX critical path. The unit also returns a zero flag for branch resolution and flags undefined operation codes.

## Interface
- `XLEN`, default 32: operand/result width. The shift amount is `b[$clog2(XLEN)-1:0]`.
- `clk`  input  1: the only clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `flush`  input  1: synchronous pipeline flush; aborts any in-flight op.
- `in_valid`  input  1: operation request.
- `in_ready`  output  1: unit can accept a request this cycle.
- `alu_control`  input  4: operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SLT, 1000 SLTU, 1001 SRA).
- `a`  input  XLEN: operand A (rs1).
- `b`  input  XLEN: operand B (rs2 or immediate).
- `out_valid`  output  1: `result`, `zero` and `err` are valid.
- `out_ready`  input  1: consumer accepts the result.
- `result`  output  XLEN: registered result.
- `zero`  output  1: registered `result == 0`.
- `err`  output  1: registered; the op code was undefined (1010–1111).
- `busy`  output  1: high in the SHIFT state.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: `result`=0, `zero`=0, `err`=0, `out_valid`=0, `busy`=0, shift counter=0. `in_ready` is 1 after reset.
- `in_ready` = IDLE, or (DONE && `out_ready`). Accept = `in_valid && in_ready && !flush`.
- On accept of a non-shift op:
  - compute and register the result, zero and err;
  - next state is DONE.
- On accept of a shift op with k = shift amount:
  - if k == 0: result = `a`, next state is DONE;
  - if k > 0: load `a` into the shift register and k into the counter; next state is SHIFT.
- SHIFT: each edge shifts by one bit and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA fills with `a[XLEN-1]`.
  - When the counter reaches 1, the final shift is registered, `zero` is updated, and the next state is DONE.
- DONE: `out_valid` is 1 and the outputs are held stable.
  - `out_ready`=1 without a new accept: next state is IDLE and `out_valid` falls.
  - `out_ready`=1 with a simultaneous accept: the new op is processed as from IDLE (back-to-back).
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT compares signed; SLTU compares unsigned. Both return 1 or 0, zero-extended.
  - Upper bits of `b` beyond the shift amount field are ignored.
- Undefined code: result=0, zero=1, err=1, completes in one cycle like a non-shift op.
- `flush` (priority over accept and over all state):
  - next state is IDLE; `out_valid`=0 and `busy`=0;
  - `result`, `zero` and `err` keep their last values;
  - the shift counter clears.
- `rst` has priority over `flush`.

## Timing
- Accept on edge N, non-shift or k=0: `out_valid` rises at edge N.
- Accept on edge N, shift with k>0: `busy` is high from edge N to edge N+k. `out_valid` rises at edge N+k.
- Maximum latency is XLEN-1 shift cycles (k=31 → 31 edges after accept).
- Back-to-back throughput for non-shift ops is 1 per cycle while `out_ready` is held at 1.
- `in_ready` depends combinationally on `out_ready` and on state only, never on `in_valid`.
- `alu_control`, `a` and `b` are sampled only on the accept edge. Input changes during SHIFT or DONE have no effect.
- Output stall: while `out_valid && !out_ready`, `result`, `zero` and `err` hold stable for any number of cycles.

## Test plan
- Reset, then ADD: a=0x7FFFFFFF, b=1, `out_ready`=1 → the next cycle shows `out_valid`=1, result=0x80000000, zero=0. After reset and before any op, all outputs are 0 and `in_ready`=1.
- SUB, then SLT/SLTU: SUB a=5, b=5 → result 0, zero=1. SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- SRA: a=0x80000000, b=0x0000003F (shift amount 31) → busy for 31 cycles, then result=0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL with b=0 → result=`a` in one cycle.
- Back-to-back with stall: stream AND, OR, XOR with `out_ready`=1 → one result per cycle. Drop `out_ready` for 3 cycles → result held and `in_ready`=0.
- Flush: issue SLL a=1, b=10, assert `flush` on the 4th SHIFT cycle → the next cycle is IDLE, `out_valid` never rises, and a following ADD completes normally.
- Undefined code 1100 → one cycle later `out_valid`=1, err=1, result=0, zero=1. The next valid op clears err.
